// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/response and external memory bus signals of the port arbiter.
// The arbiter connects through the slave modport; the pipeline/memory environment uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              stall_IF;
  logic              stall_MEM;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_rdata, bus_ack,
    output if_rdata, if_valid, mem_rdata, mem_valid, bus_req, bus_we, bus_addr, bus_wdata,
           stall_IF, stall_MEM, bus_err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_rdata, bus_ack,
    input  if_rdata, if_valid, mem_rdata, mem_valid, bus_req, bus_we, bus_addr, bus_wdata,
           stall_IF, stall_MEM, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between IF fetches and MEM loads/stores, with structural stalls.
// Optional wait-state abort is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave arb
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT} state_t;

  state_t            r_state, w_next;
  logic              r_last_mem, r_bus_req, r_bus_we, r_if_valid, r_mem_valid, r_bus_err;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata, r_if_rdata, r_mem_rdata;
  logic              w_if_el, w_mem_el, w_grant_if, w_grant_mem, w_done, w_tmo, w_stall_mem;
  logic [DATA_W-1:0] w_rdata;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state == IDLE)  r_cnt <= '0;
    else if (!arb.bus_ack)     r_cnt <= r_cnt + CNT_W'(1);
  end

  // Abort at the end of the TIMEOUT-th wait cycle; an ack in that cycle still wins.
  assign w_tmo = (r_state != IDLE) && !arb.bus_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // An aborted read returns zero data.
  assign w_rdata = arb.bus_ack ? arb.bus_rdata : '0;

  always_comb begin
    w_next      = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_done      = 1'b0;
    // A requester is not eligible in the cycle its valid is showing.
    w_if_el     = arb.if_req  & ~r_if_valid;
    w_mem_el    = arb.mem_req & ~r_mem_valid;
    case (r_state)
      IDLE: begin
        if (w_mem_el && (!w_if_el || !r_last_mem)) begin
          w_grant_mem = 1'b1;
          w_next      = MEM_WAIT;
        end else if (w_if_el) begin
          w_grant_if  = 1'b1;
          w_next      = IF_WAIT;
        end
      end
      IF_WAIT, MEM_WAIT: begin
        if (arb.bus_ack || w_tmo) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_mem  <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_if_valid  <= w_done && (r_state == IF_WAIT);
      r_mem_valid <= w_done && (r_state == MEM_WAIT);
      if (w_grant_mem) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= arb.mem_we;
        r_bus_addr  <= arb.mem_addr;
        r_bus_wdata <= arb.mem_wdata;
        r_last_mem  <= 1'b1;
      end else if (w_grant_if) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_addr  <= arb.if_addr;
        r_last_mem  <= 1'b0;
      end else if (w_done) begin
        r_bus_req   <= 1'b0;
      end
      if (w_done && (r_state == IF_WAIT))               r_if_rdata  <= w_rdata;
      if (w_done && (r_state == MEM_WAIT) && !r_bus_we) r_mem_rdata <= w_rdata;
      if (w_tmo)                                        r_bus_err   <= 1'b1;
    end
  end

  assign w_stall_mem   = arb.mem_req & ~r_mem_valid;
  assign arb.stall_MEM = w_stall_mem;
  assign arb.stall_IF  = (arb.if_req & ~r_if_valid) | w_stall_mem;
  assign arb.bus_req   = r_bus_req;
  assign arb.bus_we    = r_bus_we;
  assign arb.bus_addr  = r_bus_addr;
  assign arb.bus_wdata = r_bus_wdata;
  assign arb.if_rdata  = r_if_rdata;
  assign arb.if_valid  = r_if_valid;
  assign arb.mem_rdata = r_mem_rdata;
  assign arb.mem_valid = r_mem_valid;
  assign arb.bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a transaction-level model of the port.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) arb();
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .arb(arb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, what was latched, what completed.
  int                m_owner = 0;   // 0 none, 1 fetch, 2 data
  bit                m_last_mem = 1'b0;
  bit                m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_ifr = '0, m_memr = '0;
  bit                m_ifv = 1'b0, m_memv = 1'b0, m_err = 1'b0;
  int                m_wait = 0;
  bit                t_eif, t_emem;

  task automatic model_finish(input logic [DATA_W-1:0] d);
    if (m_owner == 1) begin
      m_ifv = 1'b1;
      m_ifr = d;
    end else begin
      m_memv = 1'b1;
      if (!m_we) m_memr = d;
    end
    m_owner = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = 0; m_last_mem = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_ifr = '0; m_memr = '0; m_ifv = 1'b0; m_memv = 1'b0; m_err = 1'b0; m_wait = 0;
    end else begin
      t_eif  = arb.if_req  && !m_ifv;
      t_emem = arb.mem_req && !m_memv;
      m_ifv  = 1'b0;
      m_memv = 1'b0;
      if (m_owner == 0) begin
        if (t_emem && (!t_eif || !m_last_mem)) begin
          m_owner = 2; m_last_mem = 1'b1; m_we = arb.mem_we;
          m_addr = arb.mem_addr; m_wdata = arb.mem_wdata; m_wait = 0;
        end else if (t_eif) begin
          m_owner = 1; m_last_mem = 1'b0; m_we = 1'b0;
          m_addr = arb.if_addr; m_wait = 0;
        end
      end else begin
        m_wait++;
        if (arb.bus_ack) model_finish(arb.bus_rdata);
        else if (TMO_EN && m_wait >= TIMEOUT) begin
          model_finish('0);
          m_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("bus_req",   64'(arb.bus_req),   64'(m_owner != 0));
    chk("bus_we",    64'(arb.bus_we),    64'(m_we));
    chk("bus_addr",  64'(arb.bus_addr),  64'(m_addr));
    chk("bus_wdata", 64'(arb.bus_wdata), 64'(m_wdata));
    chk("if_valid",  64'(arb.if_valid),  64'(m_ifv));
    chk("if_rdata",  64'(arb.if_rdata),  64'(m_ifr));
    chk("mem_valid", 64'(arb.mem_valid), 64'(m_memv));
    chk("mem_rdata", 64'(arb.mem_rdata), 64'(m_memr));
    chk("bus_err",   64'(arb.bus_err),   64'(m_err));
    chk("stall_MEM", 64'(arb.stall_MEM), 64'(arb.mem_req && !m_memv));
    chk("stall_IF",  64'(arb.stall_IF),  64'((arb.if_req && !m_ifv) || (arb.mem_req && !m_memv)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [ADDR_W-1:0] gaddr [4];
  logic [ADDR_W-1:0] exp_g [4];
  bit prev_req;
  int ng, n, lat, cnt;

  initial begin
    arb.if_req = 1'b0; arb.if_addr = '0; arb.mem_req = 1'b0; arb.mem_we = 1'b0;
    arb.mem_addr = '0; arb.mem_wdata = '0; arb.bus_rdata = '0; arb.bus_ack = 1'b0;
    exp_g = '{16'h0300, 16'h0100, 16'h0300, 16'h0100};
    gaddr = '{default: '0};

    // Reset during a data wait state
    tick(); tick(); rst_n = 1'b1;
    arb.mem_req = 1'b1; arb.mem_we = 1'b0; arb.mem_addr = 16'h0040;
    tick();
    @(negedge clk) chk("rst_pre_req", 64'(arb.bus_req), 64'd1);
    tick(); rst_n = 1'b0; arb.mem_req = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_bus_req", 64'(arb.bus_req), 64'd0);
    chk("rst_mem_rdata", 64'(arb.mem_rdata), 64'd0);
    chk("rst_if_rdata", 64'(arb.if_rdata), 64'd0);
    repeat (3) begin
      tick();
      @(negedge clk) chk("rst_no_valid", 64'(arb.mem_valid | arb.if_valid), 64'd0);
    end

    // Zero-wait fetch
    arb.if_req = 1'b1; arb.if_addr = 16'h0010;
    tick();
    arb.bus_ack = 1'b1; arb.bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("fetch_addr", 64'(arb.bus_addr), 64'h0010);
    chk("fetch_we", 64'(arb.bus_we), 64'd0);
    chk("fetch_stall", 64'(arb.stall_IF), 64'd1);
    chk("fetch_early_valid", 64'(arb.if_valid), 64'd0);
    tick(); arb.bus_ack = 1'b0; arb.bus_rdata = '0;
    @(negedge clk);
    chk("fetch_valid", 64'(arb.if_valid), 64'd1);
    chk("fetch_rdata", 64'(arb.if_rdata), 64'hDEADBEEF);
    chk("fetch_stall_off", 64'(arb.stall_IF), 64'd0);
    tick(); arb.if_req = 1'b0;
    @(negedge clk);
    chk("fetch_pulse_end", 64'(arb.if_valid), 64'd0);
    chk("fetch_no_regrant", 64'(arb.bus_req), 64'd0);

    // Store with three wait states
    tick();
    arb.mem_req = 1'b1; arb.mem_we = 1'b1; arb.mem_addr = 16'h0200;
    arb.mem_wdata = 32'h12345678; arb.bus_rdata = 32'hAAAA5555;
    tick();
    repeat (3) begin
      @(negedge clk);
      chk("st_req", 64'(arb.bus_req), 64'd1);
      chk("st_we", 64'(arb.bus_we), 64'd1);
      chk("st_addr", 64'(arb.bus_addr), 64'h0200);
      chk("st_wdata", 64'(arb.bus_wdata), 64'h12345678);
      chk("st_stall_mem", 64'(arb.stall_MEM), 64'd1);
      chk("st_stall_if", 64'(arb.stall_IF), 64'd1);
      tick();
    end
    arb.bus_ack = 1'b1;
    tick(); arb.bus_ack = 1'b0;
    @(negedge clk);
    chk("st_valid", 64'(arb.mem_valid), 64'd1);
    chk("st_rdata_kept", 64'(arb.mem_rdata), 64'd0);
    tick(); arb.mem_req = 1'b0; arb.mem_we = 1'b0;
    @(negedge clk) chk("st_pulse_end", 64'(arb.mem_valid), 64'd0);

    // Contention from reset: both requests held
    tick(); rst_n = 1'b0;
    arb.if_req = 1'b1; arb.if_addr = 16'h0100;
    arb.mem_req = 1'b1; arb.mem_we = 1'b0; arb.mem_addr = 16'h0300;
    tick(); rst_n = 1'b1;
    prev_req = 1'b0; ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      arb.bus_ack = arb.bus_req;
      arb.bus_rdata = DATA_W'($urandom);
      @(negedge clk);
      if (arb.bus_req && !prev_req) begin
        gaddr[ng] = arb.bus_addr;
        ng++;
      end
      prev_req = arb.bus_req;
    end
    chk("grant_count", 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("grant_%0d", k), 64'(gaddr[k]), 64'(exp_g[k]));
    tick(); arb.bus_ack = 1'b0; arb.if_req = 1'b0; arb.mem_req = 1'b0;
    tick();

    // Ack while idle
    arb.bus_ack = 1'b1;
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("spur_req", 64'(arb.bus_req), 64'd0);
      chk("spur_valid", 64'(arb.if_valid | arb.mem_valid), 64'd0);
    end
    arb.bus_ack = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Load to give mem_rdata a non-zero history, then a load that never acks
    tick(); arb.mem_req = 1'b1; arb.mem_we = 1'b0; arb.mem_addr = 16'h0044;
    tick(); arb.bus_ack = 1'b1; arb.bus_rdata = 32'hCAFEF00D;
    tick(); arb.bus_ack = 1'b0; arb.mem_req = 1'b0;
    @(negedge clk) chk("pre_tmo_rdata", 64'(arb.mem_rdata), 64'hCAFEF00D);
    tick(); arb.mem_req = 1'b1; arb.mem_addr = 16'h0048;
    tick();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!arb.bus_req) break;
      n++;
      tick();
    end
    chk("tmo_cycles", 64'(n), 64'd15);
    chk("tmo_valid", 64'(arb.mem_valid), 64'd1);
    chk("tmo_rdata", 64'(arb.mem_rdata), 64'd0);
    chk("tmo_err", 64'(arb.bus_err), 64'd1);
    tick(); arb.mem_req = 1'b0;
    repeat (3) tick();
    @(negedge clk) chk("tmo_err_sticky", 64'(arb.bus_err), 64'd1);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk) chk("tmo_err_reset", 64'(arb.bus_err), 64'd0);
    // Ack landing in the 15th wait cycle completes normally
    tick(); arb.mem_req = 1'b1; arb.mem_addr = 16'h004C;
    tick();
    repeat (14) tick();
    arb.bus_ack = 1'b1; arb.bus_rdata = 32'h0BADCAFE;
    tick(); arb.bus_ack = 1'b0;
    @(negedge clk);
    chk("ack15_valid", 64'(arb.mem_valid), 64'd1);
    chk("ack15_rdata", 64'(arb.mem_rdata), 64'h0BADCAFE);
    chk("ack15_err", 64'(arb.bus_err), 64'd0);
    tick(); arb.mem_req = 1'b0;
`endif

    // Random traffic, random wait states, stray acks, occasional reset
    cnt = 0; lat = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (arb.if_req) begin
        if (arb.if_valid) begin
          if ($urandom_range(1) == 1) arb.if_addr = ADDR_W'($urandom);
          else arb.if_req = 1'b0;
        end
      end else if ($urandom_range(9) < 4) begin
        arb.if_req = 1'b1; arb.if_addr = ADDR_W'($urandom);
      end
      if (arb.mem_req) begin
        if (arb.mem_valid) begin
          if ($urandom_range(1) == 1) begin
            arb.mem_addr = ADDR_W'($urandom); arb.mem_we = 1'($urandom);
            arb.mem_wdata = DATA_W'($urandom);
          end else arb.mem_req = 1'b0;
        end
      end else if ($urandom_range(9) < 3) begin
        arb.mem_req = 1'b1; arb.mem_addr = ADDR_W'($urandom);
        arb.mem_we = 1'($urandom); arb.mem_wdata = DATA_W'($urandom);
      end
      if (!arb.bus_req) begin
        cnt = 0;
        lat = $urandom_range(4);
        arb.bus_ack = ($urandom_range(19) == 0);
      end else begin
        arb.bus_ack = (cnt == lat);
        cnt++;
      end
      arb.bus_rdata = DATA_W'($urandom);
      rst_n = ($urandom_range(299) != 0);
    end
    tick(); rst_n = 1'b1; arb.bus_ack = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
